// File: rtl/mlsu_pkg.sv
// rtl/mlsu_pkg.sv - shared MLSU meta types and txn page/length geometry
package mlsu_pkg;

    localparam int PageNibs  = 8192;
    localparam int PageOffW  = 13;
    localparam int IdW       = 8;
    localparam int CntW      = 16;
    localparam int NibAddrW  = 65;
    localparam int ByteAddrW = 64;

    localparam logic [PageOffW:0] PageNibsV = (PageOffW+1)'(PageNibs);
    localparam logic [PageOffW:0] OneV      = (PageOffW+1)'(1);

    typedef enum logic [1:0] {
        MODE_ROW,
        MODE_COL,
        MODE_IDX
    } mlsu_mode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } issuer_state_e;

    typedef struct packed {
        logic [IdW-1:0]  reqId;
        mlsu_mode_e      mode;
        logic            isLoad;
        logic [CntW-1:0] rmnSeg;
    } meta_glb_t;

    typedef struct packed {
        logic [NibAddrW-1:0] segBaseAddr;
        logic [CntW-1:0]     txnNum;
        logic [CntW-1:0]     txnCnt;
        logic [PageOffW:0]   ltN;
    } meta_seglv_t;

    typedef struct packed {
        logic [ByteAddrW-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic                 write;
        logic [IdW-1:0]       id;
    } txn_req_t;

    // 14-bit intermediates keep a full 8192-nibble page count representable.
    function automatic txn_req_t txnGeom(input meta_glb_t   glb,
                                         input meta_seglv_t seg,
                                         input logic [2:0]  size_log2);
        txn_req_t                      req;
        logic [PageOffW:0]             page_off;
        logic [PageOffW:0]             nibs;
        logic [PageOffW:0]             bytes;
        logic [PageOffW:0]             beat_off;
        logic [PageOffW:0]             len_w;
        logic                          first;
        logic                          last;
        logic [NibAddrW-PageOffW-1:0]  page;
        logic [NibAddrW-1:0]           nib_addr;

        page_off = {1'b0, seg.segBaseAddr[PageOffW-1:0]};
        first    = (seg.txnCnt == '0);
        last     = (seg.txnCnt == seg.txnNum);
        page     = seg.segBaseAddr[NibAddrW-1:PageOffW]
                 + {{(NibAddrW-PageOffW-CntW){1'b0}}, seg.txnCnt};
        nib_addr = first ? seg.segBaseAddr : {page, {PageOffW{1'b0}}};

        if (first && last) begin
            nibs = seg.ltN - page_off;
        end else if (first) begin
            nibs = PageNibsV - page_off;
        end else if (last) begin
            nibs = seg.ltN;
        end else begin
            nibs = PageNibsV;
        end

        req.addr  = nib_addr[NibAddrW-1:1];
        bytes     = ({{PageOffW{1'b0}}, nib_addr[0]} + nibs + OneV) >> 1;
        beat_off  = req.addr[PageOffW:0] & ((OneV << size_log2) - OneV);
        len_w     = (beat_off + bytes - OneV) >> size_log2;
        req.len   = 8'(len_w);
        req.size  = size_log2;
        req.write = !glb.isLoad;
        req.id    = glb.reqId;
        return req;
    endfunction

endpackage

// File: rtl/mlsu_txn_issuer_if.sv
// rtl/mlsu_txn_issuer_if.sv - bus address request channel (AR/AW) between issuer and channel mux
interface mlsu_txn_issuer_if
    import mlsu_pkg::*;
#(
    parameter int AddrWidth = 64
);
    logic                 ax_valid;
    logic                 ax_ready;
    logic [AddrWidth-1:0] ax_addr;
    logic [7:0]           ax_len;
    logic [2:0]           ax_size;
    logic                 ax_write;
    logic [IdW-1:0]       ax_id;

    modport master (
        output ax_valid, ax_addr, ax_len, ax_size, ax_write, ax_id,
        input  ax_ready
    );

    modport slave (
        input  ax_valid, ax_addr, ax_len, ax_size, ax_write, ax_id,
        output ax_ready
    );
endinterface

// File: rtl/mlsu_txn_geom.sv
// rtl/mlsu_txn_geom.sv - combinational page-bounded address/length for one meta beat
module mlsu_txn_geom
    import mlsu_pkg::*;
#(
    parameter int DLEN = 128
) (
    input  meta_glb_t   glb_i,
    input  meta_seglv_t seg_i,
    output txn_req_t    req_o,
    output logic        last_o
);
    localparam logic [2:0] SizeLog2 = 3'($clog2(DLEN/8));

    assign req_o  = txnGeom(glb_i, seg_i, SizeLog2);
    assign last_o = (seg_i.txnCnt == seg_i.txnNum);
endmodule

// File: rtl/mlsu_txn_issuer.sv
// rtl/mlsu_txn_issuer.sv - turns fragmenter meta beats into bus address requests and tracks retirement
module mlsu_txn_issuer
    import mlsu_pkg::*;
#(
    parameter  int DLEN           = 128,
    parameter  int AddrWidth      = 64,
    parameter  int MaxOutstanding = 8,
    localparam int OutW           = $clog2(MaxOutstanding+1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 meta_valid_i,
    output logic                 meta_ready_o,
    input  meta_glb_t            meta_glb_i,
    input  meta_seglv_t          meta_seglv_i,
    mlsu_txn_issuer_if.master    ax,
    input  logic                 resp_valid_i,
    output logic                 req_done_o,
    output logic [IdW-1:0]       req_done_id_o,
    output logic [OutW-1:0]      outstanding_o
);
    issuer_state_e   state_q;
    txn_req_t        slice_q;
    logic            valid_q;
    logic [OutW-1:0] out_q;
    logic [OutW-1:0] out_d;
    logic [IdW-1:0]  id_q;
    logic            done_q;

    txn_req_t        geom_req;
    logic            geom_last;
    logic            ax_fire;
    logic            meta_fire;
    logic            final_beat;
    logic            retire;
    logic            credit;
    logic            drain_ok;
    logic [OutW:0]   occ;

    mlsu_txn_geom #(
        .DLEN(DLEN)
    ) u_geom (
        .glb_i (meta_glb_i),
        .seg_i (meta_seglv_i),
        .req_o (geom_req),
        .last_o(geom_last)
    );

    // A response with nothing outstanding is dropped so the counter cannot wrap.
    assign retire     = resp_valid_i && (out_q != '0);
    assign ax_fire    = valid_q && ax.ax_ready;
    assign occ        = {1'b0, out_q} + {{OutW{1'b0}}, valid_q} - {{OutW{1'b0}}, retire};
    assign credit     = occ < (OutW+1)'(MaxOutstanding);
    assign meta_ready_o = rst_ni && (state_q != S_DRAIN) && (!valid_q || ax.ax_ready) && credit;
    assign meta_fire  = meta_valid_i && meta_ready_o;
    assign final_beat = (meta_glb_i.rmnSeg == '0) && geom_last;

    always_comb begin
        out_d = out_q;
        if (ax_fire && !retire) begin
            out_d = out_q + OutW'(1);
        end else if (!ax_fire && retire) begin
            out_d = out_q - OutW'(1);
        end
    end

    assign drain_ok = !valid_q && (out_d == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            slice_q <= '0;
            valid_q <= 1'b0;
            out_q   <= '0;
            id_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            done_q <= 1'b0;

            if (meta_fire) begin
                valid_q <= 1'b1;
                slice_q <= geom_req;
            end else if (ax_fire) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (meta_fire) begin
                        id_q    <= meta_glb_i.reqId;
                        state_q <= final_beat ? S_DRAIN : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (meta_fire && final_beat) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drain_ok) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ax.ax_valid    = valid_q;
    assign ax.ax_addr     = slice_q.addr[AddrWidth-1:0];
    assign ax.ax_len      = slice_q.len;
    assign ax.ax_size     = slice_q.size;
    assign ax.ax_write    = slice_q.write;
    assign ax.ax_id       = slice_q.id;
    assign req_done_o     = done_q;
    assign req_done_id_o  = id_q;
    assign outstanding_o  = out_q;

    resp_underflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(resp_valid_i && (out_q == '0)));

endmodule

// File: tb/tb_mlsu_txn_issuer.sv
// tb/tb_mlsu_txn_issuer.sv - randomized bench for mlsu_txn_issuer against a page/byte-range model
module tb_mlsu_txn_issuer;
    import mlsu_pkg::*;

    localparam int DLEN    = 128;
    localparam int BB      = DLEN/8;
    localparam int MAX_OUT = 3;
    localparam int OUTW    = $clog2(MAX_OUT+1);

    typedef struct {
        meta_glb_t   g;
        meta_seglv_t s;
    } beat_t;

    typedef struct {
        longint addr;
        int     len;
        bit     wr;
        int     id;
    } exp_t;

    logic            clk;
    logic            rst_ni;
    logic            meta_valid;
    logic            meta_ready;
    meta_glb_t       meta_glb;
    meta_seglv_t     meta_seg;
    logic            resp_valid;
    logic            req_done;
    logic [IdW-1:0]  req_done_id;
    logic [OUTW-1:0] outstanding;

    mlsu_txn_issuer_if #(.AddrWidth(64)) ax_if ();

    mlsu_txn_issuer #(
        .DLEN(DLEN),
        .AddrWidth(64),
        .MaxOutstanding(MAX_OUT)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .meta_valid_i (meta_valid),
        .meta_ready_o (meta_ready),
        .meta_glb_i   (meta_glb),
        .meta_seglv_i (meta_seg),
        .ax           (ax_if),
        .resp_valid_i (resp_valid),
        .req_done_o   (req_done),
        .req_done_id_o(req_done_id),
        .outstanding_o(outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_total = 0;
    int     n_bad   = 0;
    beat_t  beat_q[$];
    exp_t   exp_q[$];
    exp_t   ax_log[$];
    int     m_out, m_req_id, done_cnt;
    bit     m_slice, m_drain, m_active, m_done_next;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic int pct();
        return int'($urandom_range(0, 99));
    endfunction

    // Expected request from the txn's nibble span [s,e) inside one page.
    function automatic exp_t model_txn(beat_t b);
        exp_t   r;
        longint base, p, s, e, lastb;
        int     cnt, num;
        base  = longint'(b.s.segBaseAddr);
        cnt   = int'(b.s.txnCnt);
        num   = int'(b.s.txnNum);
        p     = base / 8192 + cnt;
        s     = (cnt == 0) ? base : p * 8192;
        e     = (cnt == num) ? p * 8192 + longint'(b.s.ltN) : (p + 1) * 8192;
        r.addr = s / 2;
        lastb  = (e - 1) / 2;
        r.len  = int'(lastb / BB - r.addr / BB);
        r.wr   = !b.g.isLoad;
        r.id   = int'(b.g.reqId);
        return r;
    endfunction

    task automatic add_seg(input longint base, input longint nlen, input int id, input bit ld, input int rmn);
        longint endn, p0, pl;
        int     num;
        endn = base + nlen;
        p0   = base / 8192;
        pl   = (endn - 1) / 8192;
        num  = int'(pl - p0);
        for (int c = 0; c <= num; c++) begin
            beat_t b;
            b.g.reqId       = 8'(id);
            b.g.mode        = MODE_ROW;
            b.g.isLoad      = ld;
            b.g.rmnSeg      = 16'(rmn);
            b.s.segBaseAddr = 65'(base);
            b.s.txnNum      = 16'(num);
            b.s.txnCnt      = 16'(c);
            b.s.ltN         = 14'(endn - pl * 8192);
            beat_q.push_back(b);
        end
    endtask

    task automatic add_req(input int id, input bit ld, input int nseg, input longint base,
                           input longint nlen, input longint stride);
        for (int k = 0; k < nseg; k++) begin
            add_seg(base + k * stride, nlen, id, ld, nseg - 1 - k);
        end
    endtask

    // stop_out >= 0: stop at that model outstanding; -1: until idle; -2: fixed length
    task automatic run(input int vpct, input int rpct, input int spct, input int stop_out, input int max_cyc);
        int   cyc = 0;
        int   stall = 0;
        bit   held = 0;
        bit   reached = 0;
        bit   fire_meta, fire_ax, done_now, exp_rdy;
        exp_t e;
        while (cyc < max_cyc && !reached) begin
            @(negedge clk);
            cyc++;
            if (!held && beat_q.size() > 0 && pct() < vpct) held = 1;
            meta_valid = held;
            if (held) begin
                meta_glb = beat_q[0].g;
                meta_seg = beat_q[0].s;
            end
            if (stall > 0) begin
                stall--;
                ax_if.ax_ready = 1'b0;
            end else if (pct() < 8) begin
                stall = 5;
                ax_if.ax_ready = 1'b0;
            end else begin
                ax_if.ax_ready = (pct() < rpct);
            end
            resp_valid = (m_out > 0) && (pct() < spct);
            #1;

            chk("ax_valid", ax_if.ax_valid, m_slice);
            chk("outstanding", outstanding, m_out);
            chk("req_done", req_done, m_done_next);
            if (m_done_next) chk("done_id", req_done_id, m_req_id);
            if (req_done) done_cnt++;
            exp_rdy = !m_drain && (!m_slice || ax_if.ax_ready)
                      && (m_out + int'(m_slice) - int'(resp_valid) < MAX_OUT);
            chk("meta_ready", meta_ready, exp_rdy);
            if (ax_if.ax_valid && exp_q.size() > 0) begin
                chk("ax_addr", ax_if.ax_addr, exp_q[0].addr);
                chk("ax_len", ax_if.ax_len, exp_q[0].len);
                chk("ax_write", ax_if.ax_write, exp_q[0].wr);
                chk("ax_id", ax_if.ax_id, exp_q[0].id);
                chk("ax_size", ax_if.ax_size, $clog2(BB));
            end

            fire_meta = meta_valid && meta_ready;
            fire_ax   = ax_if.ax_valid && ax_if.ax_ready;
            done_now  = m_drain && !m_slice && (m_out - int'(resp_valid) == 0);
            if (fire_ax) begin
                e.addr = longint'(ax_if.ax_addr);
                e.len  = int'(ax_if.ax_len);
                e.wr   = ax_if.ax_write;
                e.id   = int'(ax_if.ax_id);
                ax_log.push_back(e);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                m_out++;
            end
            if (resp_valid) m_out--;
            if (fire_meta && beat_q.size() > 0) begin
                exp_q.push_back(model_txn(beat_q[0]));
                if (!m_active && !m_drain) begin
                    m_active = 1;
                    m_req_id = int'(beat_q[0].g.reqId);
                end
                if (beat_q[0].g.rmnSeg == 0 && beat_q[0].s.txnCnt == beat_q[0].s.txnNum) begin
                    m_drain  = 1;
                    m_active = 0;
                end
                void'(beat_q.pop_front());
                held    = 0;
                m_slice = 1;
            end else if (fire_ax) begin
                m_slice = 0;
            end
            if (done_now) m_drain = 0;
            m_done_next = done_now;

            if (stop_out >= 0) reached = (m_out == stop_out);
            else if (stop_out == -1)
                reached = beat_q.size() == 0 && !held && !m_slice && m_out == 0
                          && !m_drain && !m_done_next && !m_active;
        end
        if (stop_out != -2) chk("budget", reached, 1);
    endtask

    initial begin
        rst_ni = 1'b0;
        meta_valid = 1'b0;
        meta_glb = '0;
        meta_seg = '0;
        ax_if.ax_ready = 1'b0;
        resp_valid = 1'b0;
        m_out = 0; m_slice = 0; m_drain = 0; m_active = 0; m_done_next = 0;
        m_req_id = 0; done_cnt = 0;
        repeat (3) @(negedge clk);
        chk("rst_ax_valid", ax_if.ax_valid, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_meta_ready", meta_ready, 0);
        chk("rst_done", req_done, 0);
        chk("rst_ax_addr", ax_if.ax_addr, 0);
        rst_ni = 1'b1;

        // row-major load crossing one page boundary
        ax_log.delete(); done_cnt = 0;
        add_req(8'h11, 1'b1, 1, 64'h1F00, 512, 0);
        run(100, 100, 60, -1, 500);
        chk("t1_n", ax_log.size(), 2);
        if (ax_log.size() == 2) begin
            chk("t1_a0", ax_log[0].addr, 64'hF80);
            chk("t1_l0", ax_log[0].len, 7);
            chk("t1_a1", ax_log[1].addr, 64'h1000);
            chk("t1_l1", ax_log[1].len, 7);
            chk("t1_wr", ax_log[1].wr, 0);
        end
        chk("t1_done_cnt", done_cnt, 1);

        // column-major store: four 2-byte elements
        ax_log.delete(); done_cnt = 0;
        add_req(8'h22, 1'b0, 4, 0, 4, 64'h40);
        run(100, 70, 50, -1, 500);
        chk("t2_n", ax_log.size(), 4);
        if (ax_log.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t2_addr", ax_log[i].addr, 64'(i * 32));
                chk("t2_len", ax_log[i].len, 0);
                chk("t2_wr", ax_log[i].wr, 1);
            end
        end
        chk("t2_done_cnt", done_cnt, 1);

        // random requests, two handshake/response mixes
        for (int pass = 0; pass < 2; pass++) begin
            done_cnt = 0;
            for (int r = 0; r < 25; r++) begin
                longint base, nlen;
                int nseg;
                base = longint'($urandom_range(0, 1 << 20));
                nlen = (pct() < 50) ? longint'($urandom_range(1, 64)) : longint'($urandom_range(1, 20000));
                nseg = int'($urandom_range(1, 4));
                add_req(int'($urandom_range(0, 255)), pct() < 50, nseg, base, nlen,
                        nlen + longint'($urandom_range(0, 1000)));
            end
            if (pass == 0) run(70, 75, 40, -1, 30000);
            else run(90, 100, 90, -1, 30000);
            chk("rand_done_cnt", done_cnt, 25);
        end

        // credit stall, then async reset with three txns outstanding
        add_req(8'h66, 1'b1, 5, 64'h100, 8, 64'h100);
        run(100, 100, 0, MAX_OUT, 300);
        run(100, 100, 0, -2, 4);
        @(negedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_ax_valid", ax_if.ax_valid, 0);
        chk("arst_outstanding", outstanding, 0);
        chk("arst_meta_ready", meta_ready, 0);
        chk("arst_done", req_done, 0);
        meta_valid = 1'b0;
        resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("arst_hold_done", req_done, 0);
        end
        rst_ni = 1'b1;
        beat_q.delete(); exp_q.delete();
        m_out = 0; m_slice = 0; m_drain = 0; m_active = 0; m_done_next = 0;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_done", req_done, 0);
            chk("post_rst_valid", ax_if.ax_valid, 0);
            chk("post_rst_out", outstanding, 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
